uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL use one clock and one reset; reset is synchronous and active-low, ports named clk and resetn.
REQ-002 Parameter clk_freq_hz, default 27_000_000, system clock frequency in Hz.
REQ-003 Parameter baud_rate, default 115_200, serial bit rate.
REQ-004 clk  input  1  system clock; all logic samples on its rising edge.
REQ-005 resetn  input  1  synchronous active-low reset.
REQ-006 rx  input  1  asynchronous serial line, idle high, 8N1 format, LSB first.
REQ-007 o_data  output  8  received byte; valid only while o_valid=1.
REQ-008 o_valid  output  1  received byte available.
REQ-009 i_ready  input  1  consumer accepts o_data this cycle when o_valid=1.
REQ-010 o_overrun  output  1  sticky: a byte was dropped because the buffer was full.
REQ-011 o_frame_err  output  1  sticky: a stop bit was sampled low.
REQ-012 i_clear  input  1  clears both sticky flags.

Function
REQ-013 CPB SHALL be clk_freq_hz/baud_rate (integer division; 234 at defaults), HALF SHALL be CPB/2 (117); the bit counter SHALL be wide enough for CPB and SHALL never wrap during a frame.
REQ-014 rx SHALL pass through a 2-flop synchronizer; only its output (rxs) feeds logic.
REQ-015 States SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-016 IDLE: on the first cycle t0 with rxs=0, go to START.
REQ-017 START: sample rxs at t0+HALF; if 1, treat as glitch and return to IDLE with no output or flag change; if 0, go to DATA.
REQ-018 DATA: bit k (k=0..7) SHALL be sampled at t0+HALF+(k+1)*CPB and shifted in LSB first; after bit 7 go to STOP.
REQ-019 STOP: sample rxs at t0+HALF+9*CPB; if 1, deliver the byte and go to IDLE immediately (mid-stop-bit, allowing back-to-back frames); if 0, set o_frame_err, discard the byte, go to WAIT_HIGH.
REQ-020 WAIT_HIGH: remain until rxs=1, then go to IDLE; no start detection while in WAIT_HIGH.
REQ-021 Delivery: o_valid SHALL rise the cycle after the stop sample, with o_data loaded in the same cycle.
REQ-022 Handshake: a transfer occurs in a cycle where o_valid=1 and i_ready=1; o_valid SHALL be 0 the next cycle unless a new byte is delivered in that same cycle.
REQ-023 o_data SHALL hold stable while o_valid=1 and no transfer has occurred.
REQ-024 If a byte is delivered while o_valid=1 and i_ready=0, the new byte SHALL be dropped, the old byte retained, and o_overrun set.
REQ-025 If a byte is delivered in the same cycle as a transfer, the new byte SHALL load, o_valid SHALL stay 1, and no overrun SHALL be flagged.
REQ-026 i_clear SHALL zero both flags next cycle; a flag set event in the same cycle SHALL win over i_clear.
REQ-027 i_ready SHALL be ignored while o_valid=0.

Reset
REQ-028 While resetn=0 at a clock edge: state IDLE, synchronizer flops 1, counters 0, o_valid 0, o_data 0x00, o_overrun 0, o_frame_err 0.
REQ-029 Reset asserted mid-frame SHALL abandon the partial byte, with no flag set; the next frame after release SHALL be received normally.

Verification (defaults, CPB=234)
REQ-030 Frame 0x55, i_ready=1 -> o_data=0x55, o_valid high exactly 1 cycle, flags 0.
REQ-031 rx low 50 cycles, then high -> no o_valid, state back to IDLE; next frame 0xA3 -> o_data=0xA3.
REQ-032 Frames 0x41 then 0x42, i_ready=0 -> o_data stays 0x41, o_overrun=1; then i_ready=1 -> 0x41 consumed, o_valid=0; i_clear -> o_overrun=0.
REQ-033 Frame 0xFF with stop bit forced 0 for 2*CPB -> o_frame_err=1, no o_valid; after rx high, frame 0x0D -> o_data=0x0D.
REQ-034 resetn low for 1 cycle during data bit 4 of frame 0x3C -> all outputs 0; next frame 0x7E -> o_data=0x7E, flags 0.
REQ-035 Back-to-back frames 0x00, 0xFF with no idle gap, i_ready=1 -> both delivered in order, flags 0.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling from a down-counter,
// and a single-entry output buffer with a valid/ready handshake and sticky error flags.
module uart_rx #(
  parameter int clk_freq_hz = 27_000_000,
  parameter int baud_rate   = 115_200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_overrun,
  output logic       o_frame_err,
  input  logic       i_clear
);

  // state     | meaning
  // IDLE      | line idle, watching for a start edge
  // START     | waiting for start-bit midpoint to reject glitches
  // DATA      | sampling 8 data bits, LSB first
  // STOP      | waiting for stop-bit midpoint
  // WAIT_HIGH | bad stop bit; hold off start detection until line is high
  localparam int CPB   = clk_freq_hz / baud_rate;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB + 1);
  localparam logic [CNT_W-1:0] CPB_M1  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rxs_q, rxs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  logic tick, deliver, ferr_set, ovr_set, transfer;

  always_comb begin
    state_d   = state_q;
    rx_meta_d = rx;
    rxs_d     = rx_meta_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tick      = (cnt_q == '0);
    cnt_d     = tick ? cnt_q : cnt_q - CNT_ONE;
    deliver   = 1'b0;
    ferr_set  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          cnt_d   = HALF_M1;
        end
      end
      START: begin
        if (tick) begin
          if (rxs_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            cnt_d     = CPB_M1;
            bit_idx_d = 3'd0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rxs_q, shift_q[7:1]};
          cnt_d   = CPB_M1;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (tick) begin
          if (rxs_q) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A delivery coinciding with a transfer refills the buffer without overrun.
    transfer = valid_q & i_ready;
    ovr_set  = deliver & valid_q & ~i_ready;
    data_d   = data_q;
    valid_d  = valid_q;
    if (deliver && (!valid_q || i_ready)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (transfer) begin
      valid_d = 1'b0;
    end
    overrun_d   = ovr_set  | (overrun_q   & ~i_clear);
    frame_err_d = ferr_set | (frame_err_q & ~i_clear);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_overrun   = overrun_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of single frames plus hand-written
// sequences for glitch, overrun, framing error, mid-frame reset and back-to-back frames.
module tb_uart_rx;

  localparam int CPB = 27_000_000 / 115_200;

  logic       clk = 1'b0;
  logic       resetn, rx, i_ready, i_clear;
  logic [7:0] o_data;
  logic       o_valid, o_overrun, o_frame_err;

  int n_vec = 0;
  int n_err = 0;
  int valid_cycles = 0;
  logic [7:0] rcvd[$];

  uart_rx dut (
    .clk(clk), .resetn(resetn), .rx(rx),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_overrun(o_overrun), .o_frame_err(o_frame_err), .i_clear(i_clear)
  );

  always #5 clk = ~clk;

  // Consumer-side monitor: counts valid cycles and records transferred bytes.
  always @(negedge clk) begin
    if (resetn) begin
      if (o_valid) valid_cycles++;
      if (o_valid && i_ready) rcvd.push_back(o_data);
    end
  end

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    int         exp_cnt;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; rst_at >= 0 pulses resetn low for that cycle and abandons the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int stop_cycles, input int rst_at);
    logic [9:0] bits;
    int total;
    bits  = {stop_bit, b, 1'b0};
    total = 9 * CPB + stop_cycles;
    for (int c = 0; c < total; c++) begin
      rx     = (c < 9 * CPB) ? bits[c / CPB] : stop_bit;
      resetn = (c != rst_at);
      @(posedge clk);
      #1;
      if (c == rst_at) begin
        resetn = 1'b1;
        rx     = 1'b1;
        return;
      end
    end
    rx = 1'b1;
  endtask

  task automatic clear_mon();
    rcvd.delete();
    valid_cycles = 0;
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    idle(1);
    i_clear = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1, 8'h55, 1'b0};
    vecs[1] = '{8'hA3, 1'b1, 1, 8'hA3, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1, 8'hFF, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 1, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1, 8'h80, 1'b0};
    vecs[6] = '{8'hC3, 1'b0, 0, 8'h00, 1'b1};
    vecs[7] = '{8'h96, 1'b1, 1, 8'h96, 1'b0};

    resetn  = 1'b0;
    rx      = 1'b1;
    i_ready = 1'b1;
    i_clear = 1'b0;
    idle(5);
    chk("reset o_valid", o_valid, 0);
    chk("reset o_data", o_data, 8'h00);
    chk("reset o_overrun", o_overrun, 0);
    chk("reset o_frame_err", o_frame_err, 0);
    resetn = 1'b1;
    idle(5);

    for (int i = 0; i < 8; i++) begin
      clear_mon();
      send_frame(vecs[i].tx, vecs[i].stop, CPB, -1);
      idle(10);
      chk($sformatf("vec%0d transfers", i), rcvd.size(), vecs[i].exp_cnt);
      chk($sformatf("vec%0d valid cycles", i), valid_cycles, vecs[i].exp_cnt);
      if (rcvd.size() > 0) chk($sformatf("vec%0d data", i), rcvd[0], vecs[i].exp_data);
      chk($sformatf("vec%0d frame_err", i), o_frame_err, vecs[i].exp_ferr);
      chk($sformatf("vec%0d overrun", i), o_overrun, 0);
      pulse_clear();
      chk($sformatf("vec%0d frame_err cleared", i), o_frame_err, 0);
    end

    // Start glitch shorter than half a bit.
    clear_mon();
    rx = 1'b0;
    idle(50);
    rx = 1'b1;
    idle(3 * CPB);
    chk("glitch valid cycles", valid_cycles, 0);
    chk("glitch frame_err", o_frame_err, 0);
    send_frame(8'hA3, 1'b1, CPB, -1);
    idle(10);
    chk("post-glitch transfers", rcvd.size(), 1);
    if (rcvd.size() > 0) chk("post-glitch data", rcvd[0], 8'hA3);

    // Overrun: two frames with no consumer.
    clear_mon();
    i_ready = 1'b0;
    send_frame(8'h41, 1'b1, CPB, -1);
    send_frame(8'h42, 1'b1, CPB, -1);
    idle(10);
    chk("ovr o_valid held", o_valid, 1);
    chk("ovr o_data kept", o_data, 8'h41);
    chk("ovr o_overrun", o_overrun, 1);
    i_ready = 1'b1;
    idle(1);
    i_ready = 1'b0;
    chk("ovr consumed o_valid", o_valid, 0);
    chk("ovr transfers", rcvd.size(), 1);
    if (rcvd.size() > 0) chk("ovr consumed data", rcvd[0], 8'h41);
    chk("ovr sticky", o_overrun, 1);
    pulse_clear();
    chk("ovr cleared", o_overrun, 0);
    i_ready = 1'b1;

    // Framing error with the stop bit held low for two bit times.
    clear_mon();
    send_frame(8'hFF, 1'b0, 2 * CPB, -1);
    idle(10);
    chk("ferr o_frame_err", o_frame_err, 1);
    chk("ferr valid cycles", valid_cycles, 0);
    send_frame(8'h0D, 1'b1, CPB, -1);
    idle(10);
    chk("ferr next transfers", rcvd.size(), 1);
    if (rcvd.size() > 0) chk("ferr next data", rcvd[0], 8'h0D);
    chk("ferr still sticky", o_frame_err, 1);
    pulse_clear();
    chk("ferr cleared", o_frame_err, 0);

    // Reset pulse in the middle of data bit 4.
    clear_mon();
    send_frame(8'h3C, 1'b1, CPB, 5 * CPB + CPB / 2);
    chk("midrst o_valid", o_valid, 0);
    chk("midrst o_data", o_data, 8'h00);
    chk("midrst o_overrun", o_overrun, 0);
    chk("midrst o_frame_err", o_frame_err, 0);
    idle(12 * CPB);
    chk("midrst no partial byte", valid_cycles, 0);
    send_frame(8'h7E, 1'b1, CPB, -1);
    idle(10);
    chk("midrst next transfers", rcvd.size(), 1);
    if (rcvd.size() > 0) chk("midrst next data", rcvd[0], 8'h7E);
    chk("midrst next frame_err", o_frame_err, 0);

    // Back-to-back frames, no idle gap.
    clear_mon();
    send_frame(8'h00, 1'b1, CPB, -1);
    send_frame(8'hFF, 1'b1, CPB, -1);
    idle(10);
    chk("b2b transfers", rcvd.size(), 2);
    if (rcvd.size() > 1) begin
      chk("b2b first", rcvd[0], 8'h00);
      chk("b2b second", rcvd[1], 8'hFF);
    end
    chk("b2b overrun", o_overrun, 0);
    chk("b2b frame_err", o_frame_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
